traffic_sensor_array: RTL

TRAFFIC_SENSOR_ARRAY -- requirements
Module: traffic_sensor_array

---
 rtl/traffic_sensor_array.sv | 117 +++++++++++
 1 files changed

// File: rtl/traffic_sensor_array.sv
// Per-road sliding-window vehicle-count averager with a running-sum update
// and a registered "busiest road" indicator (lowest index wins ties).
module traffic_sensor_array #(
  parameter int SIZE     = 2,
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int INIT_VAL = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_en,
  input  logic [SEL_W-1:0]          next_road,
  input  logic [WIDTH-1:0]          data_in,
  output logic [CHANNELS*WIDTH-1:0] avg_flat,
  output logic                      avg_valid,
  output logic [SEL_W-1:0]          upd_road,
  output logic [SEL_W-1:0]          busiest
);

  localparam int DEPTH = 2 ** SIZE;
  localparam int SUM_W = WIDTH + SIZE;
  localparam int ACC_W = SUM_W + 1;
  localparam logic [WIDTH-1:0] INIT_SAMPLE = WIDTH'(INIT_VAL);
  localparam logic [SUM_W-1:0] INIT_SUM    = SUM_W'(INIT_VAL * DEPTH);
  localparam logic [SEL_W:0]   CH_LIMIT    = (SEL_W + 1)'(CHANNELS);

  if (2 ** SEL_W < CHANNELS) begin : g_sel_too_narrow
    $error("SEL_W too narrow to address every channel");
  end

  logic [WIDTH-1:0] win_q [CHANNELS][DEPTH];
  logic [WIDTH-1:0] win_d [CHANNELS][DEPTH];
  logic [SIZE-1:0]  ptr_q [CHANNELS];
  logic [SIZE-1:0]  ptr_d [CHANNELS];
  logic [SUM_W-1:0] sum_q [CHANNELS];
  logic [SUM_W-1:0] sum_d [CHANNELS];
  logic [WIDTH-1:0] avg_q [CHANNELS];
  logic [WIDTH-1:0] avg_d [CHANNELS];
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] upd_road_q, upd_road_d;
  logic [SEL_W-1:0] busiest_q, busiest_d;
  logic             accept;

  assign accept = sample_en && ({1'b0, next_road} < CH_LIMIT);

  // The oldest slot is the one the pointer is about to overwrite, so it is
  // subtracted out of the sum in the same step as the new sample is added.
  always_comb begin
    win_d      = win_q;
    ptr_d      = ptr_q;
    sum_d      = sum_q;
    avg_d      = avg_q;
    valid_d    = 1'b0;
    upd_road_d = upd_road_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (accept && next_road == SEL_W'(c)) begin
        win_d[c][ptr_q[c]] = data_in;
        ptr_d[c]           = ptr_q[c] + SIZE'(1);
        sum_d[c]           = SUM_W'(ACC_W'(sum_q[c]) - ACC_W'(win_q[c][ptr_q[c]])
                                    + ACC_W'(data_in));
        avg_d[c]           = WIDTH'(sum_d[c] >> SIZE);
        valid_d            = 1'b1;
        upd_road_d         = next_road;
      end
    end
  end

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    logic [WIDTH-1:0] best_val;
    best_val  = avg_q[0];
    busiest_d = '0;
    for (int c = 1; c < CHANNELS; c++) begin
      if (avg_q[c] > best_val) begin
        best_val  = avg_q[c];
        busiest_d = SEL_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int s = 0; s < DEPTH; s++) begin
          win_q[c][s] <= INIT_SAMPLE;
        end
        ptr_q[c] <= '0;
        sum_q[c] <= INIT_SUM;
        avg_q[c] <= INIT_SAMPLE;
      end
      valid_q    <= 1'b0;
      upd_road_q <= '0;
      busiest_q  <= '0;
    end else begin
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      sum_q      <= sum_d;
      avg_q      <= avg_d;
      valid_q    <= valid_d;
      upd_road_q <= upd_road_d;
      busiest_q  <= busiest_d;
    end
  end

  always_comb begin
    avg_flat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      avg_flat[c*WIDTH +: WIDTH] = avg_q[c];
    end
  end

  assign avg_valid = valid_q;
  assign upd_road  = upd_road_q;
  assign busiest   = busiest_q;

endmodule
